// File: rtl/common_types_pkg.sv
// Shared types for the memory arbiter: word type, FSM states, grant ids
// and the captured request record.
package common_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [1:0]  size_t;

  localparam size_t SZ_NONE = 2'b00;

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} arb_state_t;
  typedef enum logic       {GNT_I, GNT_D}        gnt_t;

  // Request as latched at grant time; drives the controller for the whole transaction.
  typedef struct packed {
    logic  rd;
    size_t wr;
    word_t addr;
    word_t store;
    gnt_t  gnt;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and axi_controller.
// slave = arbiter view, master = requesters plus controller view.
interface mem_arbiter_if;
  import common_types_pkg::*;

  logic  i_read;
  word_t i_addr;
  logic  i_ready;
  word_t i_load;

  logic  d_read;
  size_t d_write;
  word_t d_addr;
  word_t d_store;
  logic  d_ready;
  word_t d_load;

  logic  m_read;
  size_t m_write;
  word_t m_addr;
  word_t m_store;
  logic  m_done;
  logic  m_ready;
  word_t m_load;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_store, m_ready, m_load,
    output i_ready, i_load, d_ready, d_load, m_read, m_write, m_addr, m_store, m_done
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_store, m_ready, m_load,
    input  i_ready, i_load, d_ready, d_load, m_read, m_write, m_addr, m_store, m_done
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single memory controller.
// A winner is latched in IDLE, replayed to the controller in BUSY, and a
// one-cycle RELEASE gap lets requesters and controller settle.
module mem_arbiter
  import common_types_pkg::*;
#(
  parameter int DATA_PRIORITY = 0
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  arb_state_t state, state_nxt;
  mem_req_t   req, cap;
  gnt_t       last;

  logic pend_i, pend_d, grant, win_d;

  assign pend_i = bus.i_read;
  assign pend_d = bus.d_read | (bus.d_write != SZ_NONE);
  assign grant  = (state == IDLE) & (pend_i | pend_d);
  // Data wins if alone, if prioritised, or if fetch was served last.
  assign win_d  = pend_d & (~pend_i | (DATA_PRIORITY != 0) | (last == GNT_I));

  // Build the request record for the winner; a write masks a concurrent read.
  always_comb begin
    cap = '0;
    if (win_d) begin
      cap.rd    = (bus.d_write == SZ_NONE);
      cap.wr    = bus.d_write;
      cap.addr  = bus.d_addr;
      cap.store = bus.d_store;
      cap.gnt   = GNT_D;
    end else begin
      cap.rd    = 1'b1;
      cap.wr    = SZ_NONE;
      cap.addr  = bus.i_addr;
      cap.store = '0;
      cap.gnt   = GNT_I;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request capture and last-granted pointer, updated only on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req  <= '0;
      last <= GNT_I;
    end else if (grant) begin
      req  <= cap;
      last <= cap.gnt;
    end
  end

  // Next state and outputs; controller side is driven only from the latched request.
  always_comb begin
    state_nxt   = state;
    bus.m_read  = 1'b0;
    bus.m_write = SZ_NONE;
    bus.m_addr  = '0;
    bus.m_store = '0;
    bus.m_done  = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_load  = '0;
    bus.d_ready = 1'b0;
    bus.d_load  = '0;
    case (state)
      IDLE: if (grant) state_nxt = BUSY;
      BUSY: begin
        bus.m_read  = req.rd;
        bus.m_write = req.wr;
        bus.m_addr  = req.addr;
        bus.m_store = req.store;
        if (bus.m_ready) begin
          bus.m_done = 1'b1;
          if (req.gnt == GNT_D) begin
            bus.d_ready = 1'b1;
            bus.d_load  = bus.m_load;
          end else begin
            bus.i_ready = 1'b1;
            bus.i_load  = bus.m_load;
          end
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions plus
// hand sequences for stability, fairness, data priority and reset in BUSY.
module tb_mem_arbiter;
  import common_types_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus0();
  mem_arbiter_if bus1();

  mem_arbiter #(.DATA_PRIORITY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  mem_arbiter #(.DATA_PRIORITY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  // Controller model: ready after lat cycles of an active request.
  int    lat0 = 0, lat1 = 0, cnt0, cnt1;
  word_t rdata0 = '0, rdata1 = '0;
  wire   act0 = bus0.m_read | (|bus0.m_write);
  wire   act1 = bus1.m_read | (|bus1.m_write);
  assign bus0.m_ready = act0 && (cnt0 == lat0);
  assign bus0.m_load  = bus0.m_ready ? rdata0 : '0;
  assign bus1.m_ready = act1 && (cnt1 == lat1);
  assign bus1.m_load  = bus1.m_ready ? rdata1 : '0;

  always @(posedge clk or posedge rst) begin
    if (rst) cnt0 <= 0;
    else if (act0 && !bus0.m_ready) cnt0 <= cnt0 + 1;
    else cnt0 <= 0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cnt1 <= 0;
    else if (act1 && !bus1.m_ready) cnt1 <= cnt1 + 1;
    else cnt1 <= 0;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic ir, input word_t ia, input logic dr,
                        input logic [1:0] dw, input word_t da, input word_t ds);
    bus0.i_read = ir; bus0.i_addr = ia; bus0.d_read = dr;
    bus0.d_write = dw; bus0.d_addr = da; bus0.d_store = ds;
  endtask

  task automatic drive1(input logic ir, input word_t ia, input logic dr, input word_t da);
    bus1.i_read = ir; bus1.i_addr = ia; bus1.d_read = dr;
    bus1.d_write = 2'b00; bus1.d_addr = da; bus1.d_store = '0;
  endtask

  // Wait (bounded) until a ready pulse is seen on the chosen bus; returns negedges waited.
  task automatic wait_ready(input bit which, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(which ? (bus1.i_ready | bus1.d_ready) : (bus0.i_ready | bus0.d_ready)) && k < 20);
    if (k >= 20) chk("ready_timeout", 32'(k), 32'd0);
  endtask

  typedef struct {
    logic ir; word_t ia; logic dr; logic [1:0] dw; word_t da; word_t ds;
    int lat; word_t rdata;
    logic exp_d; logic exp_rd; logic [1:0] exp_wr; word_t exp_addr; word_t exp_store;
  } vec_t;

  vec_t vt[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k, pulses;
    logic exp_seq[4];

    // ir ia dr dw da ds lat rdata | exp_d rd wr addr store
    vt[0] = '{1, 32'h40, 0, 2'b00, 32'h0,   32'h0,        3, 32'hDEADBEEF, 0, 1, 2'b00, 32'h40,  32'h0};
    vt[1] = '{0, 32'h0,  0, 2'b10, 32'h20,  32'h1234ABCD, 2, 32'h0,        1, 0, 2'b10, 32'h20,  32'h1234ABCD};
    vt[2] = '{0, 32'h0,  1, 2'b11, 32'h44,  32'hCAFEF00D, 1, 32'h55,       1, 0, 2'b11, 32'h44,  32'hCAFEF00D};
    vt[3] = '{1, 32'h80, 1, 2'b00, 32'h100, 32'h0,        2, 32'h12345678, 0, 1, 2'b00, 32'h80,  32'h0};
    vt[4] = '{0, 32'h0,  1, 2'b00, 32'h104, 32'h0,        0, 32'h0BADF00D, 1, 1, 2'b00, 32'h104, 32'h0};
    vt[5] = '{1, 32'h10, 0, 2'b01, 32'h3,   32'hFF,       1, 32'hA0A0A0A0, 0, 1, 2'b00, 32'h10,  32'h0};
    vt[6] = '{1, 32'h14, 0, 2'b11, 32'h8,   32'hA5A5,     2, 32'h77,       1, 0, 2'b11, 32'h8,   32'hA5A5};

    drive0(0, '0, 0, 2'b00, '0, '0);
    drive1(0, '0, 0, '0);

    // Reset state: everything low, even with a request present.
    #2;
    chk("rst_m_read0", bus0.m_read, 0);
    chk("rst_m_done0", bus0.m_done, 0);
    chk("rst_m_addr1", bus1.m_addr, 0);
    bus0.i_read = 1; bus0.i_addr = 32'h40;
    @(posedge clk); #1;
    chk("rst_hold_m_read", bus0.m_read, 0);
    chk("rst_hold_i_ready", bus0.i_ready, 0);
    bus0.i_read = 0;
    @(negedge clk) rst = 1'b0;

    // Single transactions from the table.
    foreach (vt[n]) begin
      @(posedge clk); #1;
      drive0(vt[n].ir, vt[n].ia, vt[n].dr, vt[n].dw, vt[n].da, vt[n].ds);
      lat0 = vt[n].lat; rdata0 = vt[n].rdata;
      @(negedge clk);
      chk($sformatf("v%0d_idle_m_read", n), bus0.m_read, 0);
      @(posedge clk); #1;
      drive0(0, '0, 0, 2'b00, '0, '0);
      @(negedge clk);
      chk($sformatf("v%0d_m_read", n), bus0.m_read, vt[n].exp_rd);
      chk($sformatf("v%0d_m_write", n), bus0.m_write, vt[n].exp_wr);
      chk($sformatf("v%0d_m_addr", n), bus0.m_addr, vt[n].exp_addr);
      chk($sformatf("v%0d_m_store", n), bus0.m_store, vt[n].exp_store);
      k = 0;
      while (!(bus0.i_ready | bus0.d_ready) && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("v%0d_latency", n), 32'(k), 32'(vt[n].lat));
      chk($sformatf("v%0d_d_ready", n), bus0.d_ready, vt[n].exp_d);
      chk($sformatf("v%0d_i_ready", n), bus0.i_ready, !vt[n].exp_d);
      chk($sformatf("v%0d_m_done", n), bus0.m_done, 1);
      chk($sformatf("v%0d_load", n), vt[n].exp_d ? bus0.d_load : bus0.i_load, vt[n].rdata);
      chk($sformatf("v%0d_other_load", n), vt[n].exp_d ? bus0.i_load : bus0.d_load, 0);
      @(negedge clk);
      chk($sformatf("v%0d_rel_m_read", n), bus0.m_read, 0);
      chk($sformatf("v%0d_rel_m_write", n), bus0.m_write, 0);
      chk($sformatf("v%0d_rel_ready", n), bus0.i_ready | bus0.d_ready, 0);
      chk($sformatf("v%0d_rel_m_done", n), bus0.m_done, 0);
    end

    // Request fields stay latched while the requester changes them mid-transaction.
    @(posedge clk); #1;
    drive0(0, '0, 0, 2'b10, 32'h20, 32'h1234ABCD);
    lat0 = 4; rdata0 = '0;
    @(posedge clk); #1;
    bus0.d_addr = 32'h99; bus0.d_store = 32'hFFFFFFFF; bus0.d_write = 2'b01;
    @(negedge clk);
    chk("stab_m_write", bus0.m_write, 2'b10);
    chk("stab_m_addr", bus0.m_addr, 32'h20);
    chk("stab_m_store", bus0.m_store, 32'h1234ABCD);
    drive0(0, '0, 0, 2'b00, '0, '0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus0.d_ready) pulses++;
      if (bus0.m_write != 2'b00) chk("stab_m_addr_hold", bus0.m_addr, 32'h20);
    end
    chk("stab_d_ready_pulses", 32'(pulses), 32'd1);

    // Fairness: after reset data wins the first tie, then strict alternation.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    drive0(1, 32'h0, 1, 2'b00, 32'h100, '0);
    lat0 = 1; rdata0 = 32'h11;
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int t = 0; t < 4; t++) begin
      wait_ready(0, k);
      chk($sformatf("fair%0d_gap", t), 32'(k), 32'd3);
      chk($sformatf("fair%0d_d_ready", t), bus0.d_ready, exp_seq[t]);
      chk($sformatf("fair%0d_m_addr", t), bus0.m_addr, exp_seq[t] ? 32'h100 : 32'h0);
      @(negedge clk);
      chk($sformatf("fair%0d_rel_m_read", t), bus0.m_read, 0);
    end
    drive0(0, '0, 0, 2'b00, '0, '0);

    // Data priority: data keeps winning while pending; fetch after it drops.
    @(posedge clk); #1;
    drive1(1, 32'h200, 1, 32'h300);
    lat1 = 1; rdata1 = 32'h22;
    for (int t = 0; t < 4; t++) begin
      wait_ready(1, k);
      chk($sformatf("prio%0d_d_ready", t), bus1.d_ready, 1);
      chk($sformatf("prio%0d_i_ready", t), bus1.i_ready, 0);
      chk($sformatf("prio%0d_i_load", t), bus1.i_load, 0);
      chk($sformatf("prio%0d_d_load", t), bus1.d_load, 32'h22);
      @(negedge clk);
    end
    bus1.d_read = 0;
    wait_ready(1, k);
    chk("prio_i_ready", bus1.i_ready, 1);
    chk("prio_i_load", bus1.i_load, 32'h22);
    chk("prio_i_addr", bus1.m_addr, 32'h200);
    @(negedge clk);
    drive1(0, '0, 0, '0);

    // Reset during BUSY: outputs drop at once, no ready, then a fresh grant.
    @(posedge clk); #1;
    drive0(1, 32'h60, 0, 2'b00, '0, '0);
    lat0 = 5; rdata0 = 32'h600D;
    @(posedge clk);
    @(negedge clk);
    chk("rb_m_read", bus0.m_read, 1);
    chk("rb_m_addr", bus0.m_addr, 32'h60);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rb_rst_m_read", bus0.m_read, 0);
    chk("rb_rst_m_addr", bus0.m_addr, 0);
    chk("rb_rst_m_done", bus0.m_done, 0);
    pulses = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (bus0.i_ready) pulses++;
    end
    chk("rb_no_ready", 32'(pulses), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rb_regrant_m_read", bus0.m_read, 1);
    chk("rb_regrant_m_addr", bus0.m_addr, 32'h60);
    bus0.i_read = 0;
    k = 0;
    while (!bus0.i_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rb_latency", 32'(k), 32'd5);
    chk("rb_i_load", bus0.i_load, 32'h600D);
    @(negedge clk);
    chk("rb_rel_i_ready", bus0.i_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_PRIORITY, default 0: 0 = round-robin between ports; 1 = data port always wins a simultaneous request.
REQ-002 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: i_read  in  1  instruction fetch request.
REQ-005 SHALL have ports: i_addr  in  32  fetch address (word_t).
REQ-006 SHALL have ports: i_ready  out  1  fetch complete, one-cycle pulse.
REQ-007 SHALL have ports: i_load  out  32  fetch data, valid while i_ready.
REQ-008 SHALL have ports: d_read  in  1  data read request.
REQ-009 SHALL have ports: d_write  in  2  data write size: 00 none, 01 byte, 10 half, 11 word.
REQ-010 SHALL have ports: d_addr  in  32  data address.
REQ-011 SHALL have ports: d_store  in  32  write data.
REQ-012 SHALL have ports: d_ready  out  1  data access complete, one-cycle pulse.
REQ-013 SHALL have ports: d_load  out  32  read data, valid while d_ready.
REQ-014 SHALL have ports: m_read, m_write[1:0], m_addr[31:0], m_store[31:0], m_done  out  to axi_controller request side.
REQ-015 SHALL have ports: m_ready  in  1, m_load  in  32  from axi_controller.

Function
REQ-016 SHALL implement states IDLE, BUSY, RELEASE (arb_state_t).
REQ-017 A port is pending when i_read=1, or when d_read=1 or d_write!=00.
REQ-018 In IDLE, when one port is pending, it SHALL be granted at the next edge.
REQ-019 When both ports are pending and DATA_PRIORITY=0, the port not granted last SHALL win.
REQ-020 When both ports are pending and DATA_PRIORITY=1, the data port SHALL win.
REQ-021 On a grant, the state SHALL go IDLE->BUSY.
REQ-022 On a grant, the arbiter SHALL register the winner's addr, store and size, and the grant id; the grant id SHALL also update the last-granted pointer.
REQ-023 If d_read and d_write!=00 are both set, the write SHALL be issued and d_read ignored; for the instruction port, m_write SHALL be 00 and m_store 0.
REQ-024 In BUSY, m_read/m_write/m_addr/m_store SHALL be driven only from the registered request; they SHALL be stable for the whole transaction and ignore upstream changes.
REQ-025 In BUSY with m_ready=1, the following SHALL all occur combinationally in the same cycle: m_done=1, the granted port's ready=1, and its load=m_load.
REQ-026 In BUSY with m_ready=1, the state SHALL go to RELEASE at the next edge.
REQ-027 RELEASE SHALL last exactly one cycle with all m_* outputs 0, then go to IDLE; this lets the requester drop or change its request and lets axi_controller return to idle.
REQ-028 Latency: a request seen at edge N SHALL have m_read/m_write asserted in cycle N+1. The minimum request-to-ready time is therefore 1 cycle plus the controller latency.
REQ-029 Back-to-back operation: a port still pending in RELEASE SHALL NOT be granted until IDLE, giving at most one transaction per 3 cycles of arbiter overhead.
REQ-030 Fairness: with both ports continuously pending and DATA_PRIORITY=0, grants SHALL strictly alternate.
REQ-031 The ungranted port's ready SHALL remain 0, and its load SHALL be 0.
REQ-032 m_done SHALL never be asserted outside BUSY.

Reset
REQ-033 rst=1 SHALL immediately force: state IDLE, last-granted = instruction (so data wins the first tie), and registered request and grant id = 0.
REQ-034 All outputs SHALL be 0 while rst=1.
REQ-035 A reset during BUSY SHALL abandon the transaction: no ready pulse SHALL be issued for it, and the downstream controller is reset by the same rst domain.

Structure
REQ-036 arb_state_t (IDLE, BUSY, RELEASE), the grant-id enum (GNT_I, GNT_D) and word_t SHALL reside in common_types_pkg.
REQ-037 The block SHALL be a single module with no sub-module: one state register, one request-capture register and one pointer bit.

Verification
REQ-038 Fetch only: i_read=1, i_addr=0x00000040, controller returns 0xDEADBEEF after 3 cycles -> m_read=1 and m_addr=0x40 in cycle N+1; i_ready pulses one cycle with i_load=0xDEADBEEF; m_done is high in the same cycle.
REQ-039 Data write: d_write=10, d_addr=0x20, d_store=0x1234ABCD -> m_write=10, m_addr=0x20, m_store=0x1234ABCD, held stable even when d_addr changes to 0x99 mid-transaction; d_ready pulses once.
REQ-040 Simultaneous i_read (addr 0x0) and d_read (addr 0x100) after reset, DATA_PRIORITY=0 -> data is served first, then fetch; with both held pending for 4 transactions, grants alternate D,I,D,I.
REQ-041 DATA_PRIORITY=1, both held pending -> all 4 grants go to D; I is served only after d_read drops.
REQ-042 d_read=1 and d_write=11 together -> m_write=11, m_read=0.
REQ-043 rst pulsed during BUSY -> outputs 0 immediately, no ready pulse; after release, a pending i_read is granted normally.
